hsv2rgb: RTL and testbench

Pipelined HSV-to-RGB colour-space converter, the inverse of the rgb2hsv stage in the neuro_skin video path. It takes 8-bit H/S/V pixels with their video timing (de/hsync/vsync) and returns 8-bit R/G/B with the timing delayed to match. It is used to re-render HSV-domain results, such as skin masks or hue-shifted frames, for display. It accepts one pixel per enabled clock, uses integer arithmetic only and has no vendor IP cores.

---
 rtl/hsv2rgb.sv | 170 +++++++++++++++++
 tb/tb_hsv2rgb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hsv2rgb.sv
// hsv2rgb: four-stage pipelined HSV to RGB converter.
// Video timing travels alongside in a matching shift register.
module hsv2rgb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] H,
  input  logic [7:0] S,
  input  logic [7:0] V,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  // exact floor(x/255) for x in 0..65025
  function automatic logic [7:0] div255(
    input logic [15:0] x
  );
    return 8'((x + {8'd0, x[15:8]} + 16'd1) >> 8);
  endfunction

  function automatic logic [15:0] mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return 16'(a) * 16'(b);
  endfunction

  logic [10:0] h6;

  logic [2:0] s1_sector;
  logic [7:0] s1_f;
  logic [7:0] s1_s;
  logic [7:0] s1_v;
  logic [7:0] s1_sn;

  logic [2:0] s2_sector;
  logic [7:0] s2_sf;
  logic [7:0] s2_sfn;
  logic [7:0] s2_v;
  logic [7:0] s2_sn;

  logic [2:0] s3_sector;
  logic [7:0] s3_p;
  logic [7:0] s3_q;
  logic [7:0] s3_t;
  logic [7:0] s3_v;

  logic [3:0][2:0] sync_sr;

  assign h6 = 11'(H) * 11'd6;

  // stage 1: split scaled hue into sector and fraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sector <= '0;
      s1_f      <= '0;
      s1_s      <= '0;
      s1_v      <= '0;
      s1_sn     <= '0;
    end else if (ce) begin
      s1_sector <= h6[10:8];
      s1_f      <= h6[7:0];
      s1_s      <= S;
      s1_v      <= V;
      s1_sn     <= 8'd255 - S;
    end
  end

  // stage 2: saturation scaled by fraction and its complement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sector <= '0;
      s2_sf     <= '0;
      s2_sfn    <= '0;
      s2_v      <= '0;
      s2_sn     <= '0;
    end else if (ce) begin
      s2_sector <= s1_sector;
      s2_sf     <= div255(mul(s1_s, s1_f));
      s2_sfn    <= div255(mul(s1_s, 8'd255 - s1_f));
      s2_v      <= s1_v;
      s2_sn     <= s1_sn;
    end
  end

  // stage 3: the three non-V channel levels p, q, t
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_sector <= '0;
      s3_p      <= '0;
      s3_q      <= '0;
      s3_t      <= '0;
      s3_v      <= '0;
    end else if (ce) begin
      s3_sector <= s2_sector;
      s3_p      <= div255(mul(s2_v, s2_sn));
      s3_q      <= div255(mul(s2_v, 8'd255 - s2_sf));
      s3_t      <= div255(mul(s2_v, 8'd255 - s2_sfn));
      s3_v      <= s2_v;
    end
  end

  // stage 4: route levels to channels by hue sector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (ce) begin
      case (s3_sector)
        3'd0: begin
          red   <= s3_v;
          green <= s3_t;
          blue  <= s3_p;
        end
        3'd1: begin
          red   <= s3_q;
          green <= s3_v;
          blue  <= s3_p;
        end
        3'd2: begin
          red   <= s3_p;
          green <= s3_v;
          blue  <= s3_t;
        end
        3'd3: begin
          red   <= s3_p;
          green <= s3_q;
          blue  <= s3_v;
        end
        3'd4: begin
          red   <= s3_t;
          green <= s3_p;
          blue  <= s3_v;
        end
        3'd5: begin
          red   <= s3_v;
          green <= s3_p;
          blue  <= s3_q;
        end
        default: begin
          red   <= s3_v;
          green <= s3_v;
          blue  <= s3_v;
        end
      endcase
    end
  end

  // timing delay line matched to the colour pipeline depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sr <= '0;
    end else if (ce) begin
      sync_sr <= {sync_sr[2:0], {de_in, hsync_in, vsync_in}};
    end
  end

  assign de_out    = sync_sr[3][2];
  assign hsync_out = sync_sr[3][1];
  assign vsync_out = sync_sr[3][0];

endmodule

// File: tb/tb_hsv2rgb.sv
// tb_hsv2rgb: scoreboard bench for hsv2rgb.
// Stimulus pushes expected pixels; a monitor pops per enabled edge.
module tb_hsv2rgb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce = 1'b0;
  logic       de_in = 1'b0;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [7:0] H = '0;
  logic [7:0] S = '0;
  logic [7:0] V = '0;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [26:0] exp_q[$];

  hsv2rgb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .de_in     (de_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .H         (H),
    .S         (S),
    .V         (V),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] pack(
    int r, int g, int b, bit de, bit hs, bit vs
  );
    return {8'(r), 8'(g), 8'(b), de, hs, vs};
  endfunction

  // textbook HSV->RGB with integer division by 255
  function automatic logic [26:0] model(
    int h, int s, int v, bit de, bit hs, bit vs
  );
    int h6, sec, f, sf, sfn, p, q, t;
    h6  = h * 6;
    sec = h6 / 256;
    f   = h6 % 256;
    sf  = (s * f) / 255;
    sfn = (s * (255 - f)) / 255;
    p   = (v * (255 - s)) / 255;
    q   = (v * (255 - sf)) / 255;
    t   = (v * (255 - sfn)) / 255;
    case (sec)
      0:       return pack(v, t, p, de, hs, vs);
      1:       return pack(q, v, p, de, hs, vs);
      2:       return pack(p, v, t, de, hs, vs);
      3:       return pack(p, q, v, de, hs, vs);
      4:       return pack(t, p, v, de, hs, vs);
      default: return pack(v, p, q, de, hs, vs);
    endcase
  endfunction

  function automatic logic [26:0] outs();
    return {red, green, blue, de_out, hsync_out, vsync_out};
  endfunction

  task automatic check(string name, logic [26:0] act, logic [26:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rgb=%0d,%0d,%0d sync=%b expected rgb=%0d,%0d,%0d sync=%b",
               name, act[26:19], act[18:11], act[10:3], act[2:0],
               exp[26:19], exp[18:11], exp[10:3], exp[2:0]);
    end
  endtask

  // one input cycle; lit overrides the model when use_lit is set
  task automatic cyc(
    bit c, int h, int s, int v, bit de, bit hs, bit vs,
    bit use_lit = 1'b0, logic [26:0] lit = '0
  );
    @(posedge clk);
    #2;
    ce       = c;
    H        = 8'(h);
    S        = 8'(s);
    V        = 8'(v);
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    if (c && rst_n)
      exp_q.push_back(use_lit ? lit : model(h, s, v, de, hs, vs));
  endtask

  task automatic rand_cyc(bit c);
    cyc(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
        int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom),
        1'($urandom));
  endtask

  // monitor: after each edge, compare against queue, zero, or held value
  initial begin
    bit en, rs;
    logic [26:0] cur, prev;
    prev = '0;
    forever begin
      @(posedge clk);
      en = ce;
      rs = rst_n;
      #1;
      cur = outs();
      if (!rs) begin
        check("reset_hold", cur, '0);
      end else if (en) begin
        if (exp_q.size() > 4) begin
          check("queue_depth", 27'(exp_q.size()), 27'd4);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() == 4)
          check("pixel", cur, exp_q.pop_front());
        else
          check("fill_zero", cur, '0);
      end else begin
        check("ce_hold", cur, prev);
      end
      prev = cur;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_state", outs(), '0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    cyc(1, 0, 255, 255, 1, 0, 0, 1, pack(255, 0, 0, 1, 0, 0));
    cyc(1, 128, 255, 255, 1, 1, 0, 1, pack(0, 255, 255, 1, 1, 0));
    cyc(1, 85, 255, 255, 1, 0, 1, 1, pack(1, 255, 0, 1, 0, 1));
    cyc(1, 255, 255, 255, 0, 1, 1, 1, pack(255, 0, 5, 0, 1, 1));

    for (int i = 0; i < 256; i++)
      cyc(1, i, 0, 128, 1, 0, 0, 1, pack(128, 128, 128, 1, 0, 0));
    cyc(1, 77, 0, 0, 1, 0, 0, 1, pack(0, 0, 0, 1, 0, 0));
    cyc(1, 200, 0, 255, 0, 0, 0, 1, pack(255, 255, 255, 0, 0, 0));

    for (int i = 0; i < 24; i++)
      rand_cyc(i % 3 == 0);

    for (int i = 0; i < 10000; i++)
      rand_cyc($urandom_range(0, 3) != 0);

    for (int i = 0; i < 6; i++)
      cyc(1, 40 * i, 200, 180, 1, 1, 0);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", outs(), '0);
    cyc(1, 10, 10, 10, 1, 1, 1);
    cyc(1, 20, 20, 20, 1, 1, 1);
    @(posedge clk);
    #2;
    ce = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++)
      rand_cyc($urandom_range(0, 1) != 0);
    for (int i = 0; i < 4; i++)
      rand_cyc(1);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
